// File: rtl/alu32_res_if.sv
// alu32_res_if: producer/consumer handshake bundle around the ALU result stage.
interface alu32_res_if #(
    parameter int W   = 32,
    parameter int OPW = 3
);
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_result;
    logic           in_co;
    logic [OPW-1:0] in_op;
    logic           in_a_msb;
    logic           in_b_msb;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_result;
    logic [OPW-1:0] out_op;
    logic [3:0]     out_flags;
    logic           out_illegal;
    modport master (
        output in_valid, in_result, in_co, in_op, in_a_msb, in_b_msb, out_ready,
        input  in_ready, out_valid, out_result, out_op, out_flags, out_illegal
    );
    modport slave (
        input  in_valid, in_result, in_co, in_op, in_a_msb, in_b_msb, out_ready,
        output in_ready, out_valid, out_result, out_op, out_flags, out_illegal
    );
endinterface

// File: rtl/alu32_result_stage.sv
// alu32_result_stage: registers ALU result with Z/N/C/V and illegal-op flags in a two-entry skid buffer.
// Optional ALU32_RES_STATS_EN adds saturating transfer/carry counters.
module alu32_result_stage #(
    parameter int W   = 32,
    parameter int OPW = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    alu32_res_if.slave  bus
`ifdef ALU32_RES_STATS_EN
    ,
    output logic [15:0] stat_count,
    output logic [15:0] stat_carry
`endif
);
    localparam int EW = W + OPW + 5;
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
    state_t        state;
    logic [EW-1:0] head;
    logic [EW-1:0] skid;
    logic [EW-1:0] entry;
    logic          push;
    logic          pop;
    logic          add;
    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;
    assign add  = bus.in_op == OPW'(1);
    // entry layout: {illegal, N, Z, C, V, op, result}
    assign entry = {bus.in_op >= OPW'(5), bus.in_result[W-1], bus.in_result == '0,
                    add & bus.in_co,
                    add & (bus.in_a_msb == bus.in_b_msb) & (bus.in_result[W-1] != bus.in_a_msb),
                    bus.in_op, bus.in_result};
    assign {bus.out_illegal, bus.out_flags, bus.out_op, bus.out_result} = head;
    assign bus.out_valid = state != EMPTY;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= EMPTY;
            head         <= '0;
            skid         <= '0;
            bus.in_ready <= 1'b0;
        end else begin
            case (state)
                EMPTY: if (push) begin
                    head  <= entry;
                    state <= ONE;
                end
                ONE: if (push && pop) begin
                    head <= entry;
                end else if (push) begin
                    skid  <= entry;
                    state <= TWO;
                end else if (pop) begin
                    state <= EMPTY;
                end
                default: if (pop) begin
                    head  <= skid;
                    state <= ONE;
                end
            endcase
            // ready drops exactly when the next state is TWO
            bus.in_ready <= !(state == ONE && push && !pop) && !(state == TWO && !pop);
        end
    end
`ifdef ALU32_RES_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_count <= '0;
            stat_carry <= '0;
        end else if (push) begin
            if (stat_count != 16'hFFFF) stat_count <= stat_count + 16'd1;
            if (add && bus.in_co && stat_carry != 16'hFFFF) stat_carry <= stat_carry + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_alu32_result_stage.sv
// tb_alu32_result_stage: scoreboard bench with randomized and directed traffic against a flag model.
module tb_alu32_result_stage;
    localparam int W   = 32;
    localparam int OPW = 3;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    alu32_res_if #(.W(W), .OPW(OPW)) bus ();
`ifdef ALU32_RES_STATS_EN
    logic [15:0] stat_count;
    logic [15:0] stat_carry;
`endif
    alu32_result_stage #(.W(W), .OPW(OPW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
`ifdef ALU32_RES_STATS_EN
        ,
        .stat_count(stat_count),
        .stat_carry(stat_carry)
`endif
    );
    typedef struct packed {
        logic [W-1:0]   result;
        logic [OPW-1:0] op;
        logic [3:0]     flags;
        logic           illegal;
    } exp_t;
    exp_t q[$];
    int tests = 0;
    int fails = 0;
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
        end
    endtask
    // Reference: flags follow signed-add overflow semantics, carry only meaningful for ADD
    function automatic exp_t model(logic [W-1:0] r, logic co, logic [OPW-1:0] op, logic am, logic bm);
        exp_t e;
        bit is_add = (op == 1);
        bit ovf = (am == bm) && (r[W-1] != am);
        e.result  = r;
        e.op      = op;
        e.illegal = (op == 5) || (op == 6) || (op == 7);
        e.flags   = {r[W-1], r == 0, is_add ? co : 1'b0, is_add ? ovf : 1'b0};
        return e;
    endfunction
    task automatic send(input logic v, input logic [W-1:0] r, input logic co,
                        input logic [OPW-1:0] op, input logic am, input logic bm, input logic ordy);
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_result = r;
        bus.in_co     = co;
        bus.in_op     = op;
        bus.in_a_msb  = am;
        bus.in_b_msb  = bm;
        bus.out_ready = ordy;
        if (v && bus.in_ready && rst_n) q.push_back(model(r, co, op, am, bm));
    endtask
    task automatic idle(input logic ordy);
        send(1'b0, $urandom, $urandom_range(0, 1), OPW'($urandom_range(0, 7)), 1'b0, 1'b0, ordy);
    endtask
    task automatic drain();
        for (int i = 0; i < 20 && q.size() != 0; i++) idle(1'b1);
        idle(1'b1);
        check("drain_empty", 64'(q.size()), 64'd0);
    endtask
    task automatic check_cleared(input string tag);
        check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd0);
        check({tag, "_out_result"}, 64'(bus.out_result), 64'd0);
        check({tag, "_out_op_flags_ill"}, {bus.out_op, bus.out_flags, bus.out_illegal}, 64'd0);
    endtask
    // Monitor: every output transfer must match the head of the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_output", 64'(bus.out_result), 64'hDEAD);
                end else begin
                    e = q.pop_front();
                    check("out_result", 64'(bus.out_result), 64'(e.result));
                    check("out_op", 64'(bus.out_op), 64'(e.op));
                    check("out_flags", 64'(bus.out_flags), 64'(e.flags));
                    check("out_illegal", 64'(bus.out_illegal), 64'(e.illegal));
                end
            end
        end
    end
    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
    initial begin
        bus.in_valid = 1'b0;
        bus.in_result = '0;
        bus.in_co = 1'b0;
        bus.in_op = '0;
        bus.in_a_msb = 1'b0;
        bus.in_b_msb = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) idle(1'b0);
        #2 check_cleared("reset");
`ifdef ALU32_RES_STATS_EN
        check("stat_reset", {stat_count, stat_carry}, 64'd0);
`endif
        rst_n = 1'b1;
        idle(1'b0);
        #2 check("ready_after_reset", 64'(bus.in_ready), 64'd1);
        // single ADD with zero result, carry and overflow
        send(1'b1, 32'h0, 1'b1, 3'd1, 1'b1, 1'b1, 1'b1);
        idle(1'b1);
        #2 check("add_valid", 64'(bus.out_valid), 64'd1);
        check("add_flags", 64'(bus.out_flags), 64'b0111);
        idle(1'b1);
        #2 check("add_valid_drop", 64'(bus.out_valid), 64'd0);
        // fill both entries with the consumer stalled
        send(1'b1, 32'h8000_0001, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
        send(1'b1, 32'h1, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0);
        idle(1'b0);
        #2 check("two_in_ready", 64'(bus.in_ready), 64'd0);
        check("two_hold_result", 64'(bus.out_result), 64'h8000_0001);
        idle(1'b0);
        #2 check("two_stable", 64'(bus.out_result), 64'h8000_0001);
        check("xor_flags", 64'(bus.out_flags), 64'b1000);
        idle(1'b1);
        idle(1'b1);
        #2 check("ready_after_pop", 64'(bus.in_ready), 64'd1);
        drain();
        // simultaneous push/pop in ONE
        send(1'b1, $urandom, 1'b1, 3'd4, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            send(1'b1, $urandom, $urandom_range(0, 1), OPW'(i % 5), $urandom_range(0, 1),
                 $urandom_range(0, 1), 1'b1);
            #2 check("pushpop_valid", 64'(bus.out_valid), 64'd1);
            check("pushpop_ready", 64'(bus.in_ready), 64'd1);
        end
        drain();
        // illegal op
        send(1'b1, 32'h0, 1'b1, 3'd6, 1'b0, 1'b0, 1'b1);
        idle(1'b1);
        #2 check("illegal_bit", 64'(bus.out_illegal), 64'd1);
        check("illegal_flags", 64'(bus.out_flags), 64'b0100);
        drain();
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            send($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0 ? 32'h0 : $urandom,
                 $urandom_range(0, 1), OPW'($urandom_range(0, 7)), $urandom_range(0, 1),
                 $urandom_range(0, 1), $urandom_range(0, 2) != 0);
        end
        drain();
        // reset while holding two entries
        send(1'b1, 32'hFFFF_FFFF, 1'b1, 3'd1, 1'b1, 1'b1, 1'b0);
        send(1'b1, 32'h1234_5678, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        #2 check("pre_reset_two", 64'(bus.in_ready), 64'd0);
        idle(1'b0);
        rst_n = 1'b0;
        q.delete();
        idle(1'b0);
        #2 check_cleared("mid_reset");
        rst_n = 1'b1;
        idle(1'b0);
        #2 check("ready_after_mid_reset", 64'(bus.in_ready), 64'd1);
        check("valid_after_mid_reset", 64'(bus.out_valid), 64'd0);
`ifdef ALU32_RES_STATS_EN
        rst_n = 1'b0;
        idle(1'b1);
        rst_n = 1'b1;
        idle(1'b1);
        for (int i = 0; i < 70000; i++) send(1'b1, $urandom, 1'b1, 3'd1, 1'b0, 1'b0, 1'b1);
        drain();
        check("stat_count_sat", 64'(stat_count), 64'hFFFF);
        check("stat_carry_sat", 64'(stat_carry), 64'hFFFF);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu32_result_stage.md
Name: alu32_result_stage

Overview:
- Registered result/writeback stage directly downstream of the 32-bit gate-level ALU.
- Captures ALU result word, carry-out, op select and operand sign bits under a valid/ready handshake.
- Derives status flags Z/N/C/V and an illegal-op flag, and buffers up to two results in a skid buffer so the consumer can stall without losing data.
- Feeds the register-file writeback and flags register.

Parameters:
- W, 32, datapath width; flags logic uses bit W-1 as the sign bit.
- OPW, 3, width of the op-select field (matches the ALU select A[2:0]).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- in_valid  input  1  ALU result on in_* is valid this cycle.
- in_ready  output  1  stage can accept a result this cycle.
- in_result  input  W  ALU result word (Cout).
- in_co  input  1  ALU carry-out (CO).
- in_op  input  OPW  op select that produced in_result.
- in_a_msb  input  1  In1[W-1].
- in_b_msb  input  1  In2[W-1].
- out_valid  output  1  out_* holds a buffered result.
- out_ready  input  1  consumer accepts out_* this cycle.
- out_result  output  W  buffered result word.
- out_op  output  OPW  op of buffered result.
- out_flags  output  4  {N,Z,C,V} of buffered result.
- out_illegal  output  1  buffered op code is 5, 6 or 7.

Behaviour:
- Op encoding: 0 XOR, 1 ADD, 2 AND, 3 OR, 4 NOT, 5-7 illegal.
- Transfer in occurs when in_valid && in_ready; transfer out occurs when out_valid && out_ready.
- Flags are computed at capture from the in_* signals:
  - Z = (in_result == 0).
  - N = in_result[W-1].
  - C = in_co if op == ADD, else 0.
  - V = (in_a_msb == in_b_msb) && (in_result[W-1] != in_a_msb) if op == ADD, else 0.
  - Illegal ops are still captured with out_illegal = 1 and flags computed by the same rules (C = V = 0).
- Storage: head register (drives out_*) plus one skid register.
- States: EMPTY, ONE (head full), TWO (head and skid full). in_ready is registered: in_ready = 1 in EMPTY and ONE, 0 in TWO and during reset.
- Transitions:
  - EMPTY: push -> ONE; head loaded.
  - ONE, push only -> TWO; skid loaded.
  - ONE, pop only -> EMPTY.
  - ONE, push and pop together -> stays ONE; head reloaded with the new input.
  - ONE, neither -> hold.
  - TWO, pop -> ONE; skid moves to head. No push is possible in TWO.
- Latency: accept at edge n means out_valid is high after edge n. Throughput is 1 result per cycle when out_ready is held high.
- Order is strictly FIFO. out_* are stable while out_valid && !out_ready.
- Reset (rst_n low at an edge, including mid-operation): state -> EMPTY, out_valid = 0, out_result = 0, out_op = 0, out_flags = 0, out_illegal = 0, in_ready = 0. in_ready rises at the first edge with rst_n high. Buffered data is discarded.
- in_* are ignored when in_valid = 0 or in_ready = 0.

Optional Feature:
- Macro ALU32_RES_STATS_EN.
- With the macro defined:
  - Adds outputs stat_count (16) and stat_carry (16).
  - stat_count increments on every input transfer.
  - stat_carry increments on every input transfer with op == ADD && in_co == 1.
  - Both saturate at 16'hFFFF and clear on reset.
- Without the macro: the ports and logic are absent, and the behaviour above is unchanged.

Test Plan:
- Reset then single ADD, in_result = 32'h0000_0000, in_co = 1, a_msb = b_msb = 1, out_ready = 1 -> next cycle out_valid = 1, flags N = 0, Z = 1, C = 1, V = 1; out_valid = 0 the cycle after.
- Back-to-back XOR 32'h8000_0001 then OR 32'h1 with out_ready = 0 -> state TWO, in_ready = 0; raise out_ready -> XOR (N = 1, C = 0) then OR delivered in order, in_ready returns to 1 after the first pop.
- ONE state with simultaneous push/pop for 8 cycles, ops 0..4 cycling -> one result out per cycle, out_valid never drops, order preserved.
- op = 3'd6, in_result = 0 -> out_illegal = 1, Z = 1, C = V = 0.
- Reset asserted while in TWO -> next edge out_valid = 0, all out_* = 0, in_ready = 0; in_ready = 1 one edge after rst_n rises.
- ALU32_RES_STATS_EN: 70000 ADD transfers with in_co = 1 -> stat_count = stat_carry = 16'hFFFF (saturated), no wrap.
